// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the fractional baud generator and the UART bit engines.
// The slave side belongs to the generator; the master side drives configuration and consumes ticks.
interface uart_baud_gen_if #(
  parameter int DivWidth  = 16,
  parameter int FracWidth = 4
);
  logic                 clear_i;
  logic                 enable_i;
  logic                 cfg_load_i;
  logic [DivWidth-1:0]  div_int_i;
  logic [FracWidth-1:0] div_frac_i;
  logic                 os_tick_o;
  logic                 sample_tick_o;
  logic                 bit_tick_o;
  logic                 cfg_err_o;

  modport master (
    output clear_i, enable_i, cfg_load_i, div_int_i, div_frac_i,
    input  os_tick_o, sample_tick_o, bit_tick_o, cfg_err_o
  );

  modport slave (
    input  clear_i, enable_i, cfg_load_i, div_int_i, div_frac_i,
    output os_tick_o, sample_tick_o, bit_tick_o, cfg_err_o
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud generator: oversample tick every div_int + div_frac/2^FracWidth clocks,
// plus per-bit and mid-bit sample ticks derived from the oversample index.
module uart_baud_gen #(
  parameter int DivWidth   = 16,
  parameter int FracWidth  = 4,
  parameter int Oversample = 16,
  parameter int MarkPos    = 8,
  parameter int DefaultDiv = 4
) (
  input logic            clk_i,
  input logic            reset_i,
  uart_baud_gen_if.slave bus
);
  localparam int CntWidth = DivWidth + 1;
  localparam int OsiWidth = (Oversample > 2) ? $clog2(Oversample) : 1;

  logic [CntWidth-1:0]  cnt_r,       cnt_s;
  logic [OsiWidth-1:0]  osi_r,       osi_s;
  logic [FracWidth-1:0] acc_r,       acc_s;
  logic                 carry_r,     carry_s;
  logic [DivWidth-1:0]  div_int_r,   div_int_s;
  logic [FracWidth-1:0] div_frac_r,  div_frac_s;
  logic [DivWidth-1:0]  pend_int_r,  pend_int_s;
  logic [FracWidth-1:0] pend_frac_r, pend_frac_s;
  logic                 pend_vld_r,  pend_vld_s;
  logic                 os_tick_r,   os_tick_s;
  logic                 sample_r,    sample_s;
  logic                 bit_r,       bit_s;
  logic                 cfg_err_r,   cfg_err_s;

  logic [CntWidth-1:0]  plen_s;
  logic                 terminal_s;
  logic                 load_ok_s;
  logic [FracWidth:0]   sum_s;

  // Period length, terminal detect and accumulator sum for the current period.
  always_comb begin
    plen_s     = {1'b0, div_int_r} + CntWidth'(carry_r);
    // >= rather than == so a divisor shrunk while paused cannot strand cnt past the end.
    terminal_s = bus.enable_i && !bus.clear_i && ((cnt_r + CntWidth'(1)) >= plen_s);
    load_ok_s  = bus.cfg_load_i && (bus.div_int_i >= DivWidth'(2));
    sum_s      = {1'b0, acc_r} + {1'b0, div_frac_r};
  end

  // Next-state logic for counters, tick outputs and configuration.
  always_comb begin
    cnt_s       = cnt_r;
    osi_s       = osi_r;
    acc_s       = acc_r;
    carry_s     = carry_r;
    div_int_s   = div_int_r;
    div_frac_s  = div_frac_r;
    pend_int_s  = pend_int_r;
    pend_frac_s = pend_frac_r;
    pend_vld_s  = pend_vld_r;
    os_tick_s   = 1'b0;
    sample_s    = 1'b0;
    bit_s       = 1'b0;
    cfg_err_s   = cfg_err_r;

    if (bus.clear_i) begin
      cnt_s     = '0;
      osi_s     = '0;
      acc_s     = '0;
      carry_s   = 1'b0;
      cfg_err_s = 1'b0;
    end else if (terminal_s) begin
      cnt_s     = '0;
      os_tick_s = 1'b1;
      sample_s  = (osi_r == OsiWidth'(MarkPos));
      bit_s     = (osi_r == OsiWidth'(Oversample - 1));
      if (osi_r == OsiWidth'(Oversample - 1)) begin
        osi_s = '0;
      end else begin
        osi_s = osi_r + OsiWidth'(1);
      end
      if (pend_vld_r) begin
        div_int_s  = pend_int_r;
        div_frac_s = pend_frac_r;
        pend_vld_s = 1'b0;
        acc_s      = '0;
        carry_s    = 1'b0;
      end else begin
        {carry_s, acc_s} = sum_s;
      end
    end else if (bus.enable_i) begin
      cnt_s = cnt_r + CntWidth'(1);
    end else begin
      cnt_s = cnt_r;
    end

    if (load_ok_s) begin
      cfg_err_s = 1'b0;
      if (bus.clear_i || !bus.enable_i) begin
        div_int_s  = bus.div_int_i;
        div_frac_s = bus.div_frac_i;
        pend_vld_s = 1'b0;
        acc_s      = '0;
        carry_s    = 1'b0;
      end else begin
        pend_int_s  = bus.div_int_i;
        pend_frac_s = bus.div_frac_i;
        pend_vld_s  = 1'b1;
      end
    end else if (bus.cfg_load_i) begin
      cfg_err_s = 1'b1;
    end else begin
      pend_vld_s = pend_vld_s;
    end
  end

  // State and output registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r       <= '0;
      osi_r       <= '0;
      acc_r       <= '0;
      carry_r     <= 1'b0;
      div_int_r   <= DivWidth'(DefaultDiv);
      div_frac_r  <= '0;
      pend_int_r  <= '0;
      pend_frac_r <= '0;
      pend_vld_r  <= 1'b0;
      os_tick_r   <= 1'b0;
      sample_r    <= 1'b0;
      bit_r       <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      cnt_r       <= cnt_s;
      osi_r       <= osi_s;
      acc_r       <= acc_s;
      carry_r     <= carry_s;
      div_int_r   <= div_int_s;
      div_frac_r  <= div_frac_s;
      pend_int_r  <= pend_int_s;
      pend_frac_r <= pend_frac_s;
      pend_vld_r  <= pend_vld_s;
      os_tick_r   <= os_tick_s;
      sample_r    <= sample_s;
      bit_r       <= bit_s;
      cfg_err_r   <= cfg_err_s;
    end
  end

  assign bus.os_tick_o     = os_tick_r;
  assign bus.sample_tick_o = sample_r;
  assign bus.bit_tick_o    = bit_r;
  assign bus.cfg_err_o     = cfg_err_r;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed scenarios plus random traffic against a period-level model
// where period k after a (re)start lasts div + floor(k*f/2^F) - floor((k-1)*f/2^F) clocks.
module tb_uart_baud_gen;
  localparam int DIV_W   = 16;
  localparam int FRAC_W  = 4;
  localparam int OS      = 16;
  localparam int MARK    = 8;
  localparam int DEF_DIV = 4;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk_i = ~clk_i;

  uart_baud_gen_if #(.DivWidth(DIV_W), .FracWidth(FRAC_W)) bus ();

  uart_baud_gen #(
    .DivWidth(DIV_W), .FracWidth(FRAC_W), .Oversample(OS), .MarkPos(MARK), .DefaultDiv(DEF_DIV)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  typedef struct packed {
    int div; int frac; bit pv; int pdiv; int pfrac;
    int el; int k; int osi; bit os; bit smp; bit bt; bit err;
  } mstate_t;

  mstate_t m;
  logic [3:0] obs, exp_v;
  assign obs   = {bus.os_tick_o, bus.sample_tick_o, bus.bit_tick_o, bus.cfg_err_o};
  assign exp_v = {m.os, m.smp, m.bt, m.err};

  function automatic mstate_t model_reset();
    mstate_t r;
    r = '0;
    r.div = DEF_DIV;
    return r;
  endfunction

  function automatic int period_len(int div, int frac, int k);
    if (k == 0) return div;
    return div + (k * frac) / (1 << FRAC_W) - ((k - 1) * frac) / (1 << FRAC_W);
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit clr, bit en, bit ld, int di, int df);
    mstate_t n;
    bit ok;
    int len;
    n = s; n.os = 1'b0; n.smp = 1'b0; n.bt = 1'b0;
    ok  = ld && (di >= 2);
    len = period_len(s.div, s.frac, s.k);
    if (clr) begin
      n.el = 0; n.k = 0; n.osi = 0; n.err = 1'b0;
      if (ok) begin n.div = di; n.frac = df; n.pv = 1'b0; end
    end else if (en) begin
      if (s.el + 1 >= len) begin
        n.os = 1'b1; n.smp = (s.osi == MARK); n.bt = (s.osi == OS - 1);
        n.osi = (s.osi + 1) % OS; n.el = 0;
        if (s.pv) begin n.div = s.pdiv; n.frac = s.pfrac; n.pv = 1'b0; n.k = 0; end
        else n.k = s.k + 1;
      end else begin
        n.el = s.el + 1;
      end
      if (ok) begin n.pdiv = di; n.pfrac = df; n.pv = 1'b1; end
    end else if (ok) begin
      n.div = di; n.frac = df; n.pv = 1'b0; n.k = 0;
    end
    if (ld) n.err = !ok;
    return n;
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) m <= model_reset();
    else m <= model_step(m, bus.clear_i, bus.enable_i, bus.cfg_load_i,
                         int'(bus.div_int_i), int'(bus.div_frac_i));
  end

  task automatic apply_reset();
    reset_i = 1'b1;
    bus.clear_i = 1'b0; bus.enable_i = 1'b0; bus.cfg_load_i = 1'b0;
    bus.div_int_i = '0; bus.div_frac_i = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic load_disabled(input int di, input int df);
    bus.enable_i = 1'b0; bus.cfg_load_i = 1'b1;
    bus.div_int_i = DIV_W'(di); bus.div_frac_i = FRAC_W'(df);
    @(negedge clk_i);
    bus.cfg_load_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_outputs got %b want 0000", obs); end
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (obs !== 4'b0000 || obs !== exp_v)
        begin errors++; $display("FAIL idle_after_reset got %b want 0000 (model %b)", obs, exp_v); end
    end
  endtask

  task automatic test_default_rate();
    int first_os = -1, nos = 0, first_s = -1, first_b = -1, second_b = -1;
    apply_reset();
    bus.enable_i = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL default_model edge %0d got %b want %b", e, obs, exp_v); end
      if (bus.os_tick_o) begin nos++; if (first_os < 0) first_os = e; end
      if (bus.sample_tick_o && first_s < 0) first_s = e;
      if (bus.bit_tick_o) begin if (first_b < 0) first_b = e; else if (second_b < 0) second_b = e; end
    end
    checks++; if (first_os !== 4)   begin errors++; $display("FAIL default_first_os got %0d want 4", first_os); end
    checks++; if (nos !== 50)       begin errors++; $display("FAIL default_os_count got %0d want 50", nos); end
    checks++; if (first_s !== 36)   begin errors++; $display("FAIL default_first_sample got %0d want 36", first_s); end
    checks++; if (first_b !== 64)   begin errors++; $display("FAIL default_first_bit got %0d want 64", first_b); end
    checks++; if (second_b !== 128) begin errors++; $display("FAIL default_second_bit got %0d want 128", second_b); end
  endtask

  task automatic test_fractional();
    int os_q[$];
    int bit_e = -1, nbits = 0;
    apply_reset();
    load_disabled(3, 8);
    bus.enable_i = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL frac_model edge %0d got %b want %b", e, obs, exp_v); end
      if (bus.os_tick_o) os_q.push_back(e);
      if (bus.bit_tick_o) begin nbits++; bit_e = e; end
    end
    checks++;
    if (os_q.size() < 16) begin
      errors++; $display("FAIL frac_tick_count got %0d want >=16", os_q.size());
    end else begin
      if (os_q[0] !== 3 || os_q[1] !== 6 || os_q[2] !== 10 || os_q[3] !== 13 || os_q[4] !== 17)
        begin errors++; $display("FAIL frac_first_ticks got %0d %0d %0d %0d %0d want 3 6 10 13 17",
                                 os_q[0], os_q[1], os_q[2], os_q[3], os_q[4]); end
      checks++;
      if (os_q[15] !== 55) begin errors++; $display("FAIL frac_16th_tick got %0d want 55", os_q[15]); end
    end
    checks++;
    if (nbits !== 1 || bit_e !== 55) begin errors++; $display("FAIL frac_bit_tick got n=%0d at %0d want n=1 at 55", nbits, bit_e); end
  endtask

  task automatic test_cfg_err();
    int os_q[$];
    apply_reset();
    bus.enable_i = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 11 || e == 21) begin
        bus.cfg_load_i = 1'b1; bus.div_int_i = (e == 11) ? DIV_W'(1) : DIV_W'(5); bus.div_frac_i = '0;
      end else begin
        bus.cfg_load_i = 1'b0;
      end
      @(negedge clk_i);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cfg_model edge %0d got %b want %b", e, obs, exp_v); end
      if (e == 11) begin
        checks++; if (bus.cfg_err_o !== 1'b1) begin errors++; $display("FAIL cfg_err_set got %b want 1", bus.cfg_err_o); end
      end
      if (e == 21) begin
        checks++; if (bus.cfg_err_o !== 1'b0) begin errors++; $display("FAIL cfg_err_clr got %b want 0", bus.cfg_err_o); end
      end
      if (bus.os_tick_o) os_q.push_back(e);
    end
    checks++;
    if (os_q.size() !== 9) begin
      errors++; $display("FAIL cfg_tick_count got %0d want 9", os_q.size());
    end else if (os_q[2] !== 12 || os_q[5] !== 24 || os_q[6] !== 29 || os_q[8] !== 39) begin
      errors++; $display("FAIL cfg_tick_times got %0d %0d %0d %0d want 12 24 29 39", os_q[2], os_q[5], os_q[6], os_q[8]);
    end
  endtask

  task automatic test_enable_gap();
    int n_en = 0, ticks = 0, pre, tot = 0, exp_ticks = 0, len;
    apply_reset();
    load_disabled(3, 8);
    pre = $urandom_range(5, 40);
    bus.enable_i = 1'b1;
    while (n_en < pre) begin
      @(negedge clk_i); n_en++;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL gap_model_pre en %0d got %b want %b", n_en, obs, exp_v); end
      if (bus.os_tick_o) ticks++;
    end
    bus.enable_i = 1'b0;
    repeat (7) begin
      @(negedge clk_i);
      checks++;
      if (obs !== 4'b0000) begin errors++; $display("FAIL gap_outputs_low got %b want 0000", obs); end
    end
    bus.enable_i = 1'b1;
    while (n_en < 1000) begin
      @(negedge clk_i); n_en++;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL gap_model_post en %0d got %b want %b", n_en, obs, exp_v); end
      if (bus.os_tick_o) ticks++;
    end
    for (int j = 0; j < 1000; j++) begin
      len = period_len(3, 8, j);
      if (tot + len > 1000) break;
      tot += len; exp_ticks++;
    end
    checks++;
    if (ticks !== exp_ticks) begin errors++; $display("FAIL gap_tick_total got %0d want %0d", ticks, exp_ticks); end
  endtask

  task automatic test_clear_load();
    int first_os = -1, first_s = -1, first_b = -1;
    apply_reset();
    bus.enable_i = 1'b1;
    repeat ($urandom_range(70, 130)) @(negedge clk_i);
    bus.clear_i = 1'b1; bus.cfg_load_i = 1'b1; bus.div_int_i = DIV_W'(6); bus.div_frac_i = '0;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk_i);
      bus.clear_i = 1'b0; bus.cfg_load_i = 1'b0;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL clr_model edge %0d got %b want %b", e, obs, exp_v); end
      if (bus.os_tick_o && first_os < 0) first_os = e;
      if (bus.sample_tick_o && first_s < 0) first_s = e;
      if (bus.bit_tick_o && first_b < 0) first_b = e;
    end
    checks++; if (first_os !== 7) begin errors++; $display("FAIL clr_first_os got %0d want 7", first_os); end
    checks++; if (first_s !== 55) begin errors++; $display("FAIL clr_first_sample got %0d want 55", first_s); end
    checks++; if (first_b !== 97) begin errors++; $display("FAIL clr_first_bit got %0d want 97", first_b); end
  endtask

  task automatic test_async_reset();
    int os_q[$];
    apply_reset();
    bus.enable_i = 1'b1;
    repeat (30) @(negedge clk_i);
    bus.cfg_load_i = 1'b1; bus.div_int_i = DIV_W'(7);
    @(negedge clk_i);
    bus.div_int_i = DIV_W'(0);
    @(negedge clk_i);
    bus.cfg_load_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (bus.cfg_err_o !== 1'b1) begin errors++; $display("FAIL arst_err_before got %b want 1", bus.cfg_err_o); end
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL arst_immediate got %b want 0000", obs); end
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL arst_model edge %0d got %b want %b", e, obs, exp_v); end
      if (bus.os_tick_o) os_q.push_back(e);
    end
    checks++;
    if (os_q.size() !== 10 || os_q[1] !== 8 || os_q[9] !== 40)
      begin errors++; $display("FAIL arst_default_period got n=%0d want 10 ticks every 4", os_q.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.enable_i   = ($urandom % 8) != 0;
      bus.clear_i    = ($urandom % 64) == 0;
      bus.cfg_load_i = ($urandom % 24) == 0;
      bus.div_int_i  = DIV_W'($urandom_range(0, 9));
      bus.div_frac_i = FRAC_W'($urandom % 16);
      @(negedge clk_i);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_model cycle %0d got %b want %b", c, obs, exp_v); end
    end
    bus.enable_i = 1'b0; bus.clear_i = 1'b0; bus.cfg_load_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_fractional();
    test_cfg_err();
    test_enable_gap();
    test_clear_load();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
